// File: rtl/var_delay_line_pkg.sv
// Shared types and helpers for the variable delay line.
package var_delay_line_pkg;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_DELAY = 32'd1;

  // Requested delays of 0 behave as 1; anything beyond the buffer capacity saturates.
  function automatic logic [31:0] clamp_delay(input logic [31:0] req, input logic [31:0] max_d);
    logic [31:0] res;
    if (req == 32'd0) begin
      res = MIN_DELAY;
    end else if (req > max_d) begin
      res = max_d;
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/var_delay_ram.sv
// Single-port read-first sample store for the delay line; contents are not reset.
module var_delay_ram #(
  parameter int DEPTH = 63,
  parameter int DW    = 128,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Read the old word, then overwrite it, on each enabled access.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem_r[addr];
      if (we) begin
        mem_r[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/var_delay_line.sv
// Multi-lane delay line with a runtime-selectable delay counted in en-cycles.
// Optional build macro VAR_DELAY_LINE_ZERO_FILL_EN blanks out whenever out_valid is low.
module var_delay_line
  import var_delay_line_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LANES     = 4,
  parameter int MAX_DELAY = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           cfg_load,
  input  logic [$clog2(MAX_DELAY+1)-1:0] cfg_delay,
  input  logic [LANES*WIDTH-1:0]         in,
  output logic [LANES*WIDTH-1:0]         out,
  output logic                           out_valid,
  output logic [$clog2(MAX_DELAY+1)-1:0] cur_delay
);

  localparam int DW    = LANES * WIDTH;
  localparam int CW    = $clog2(MAX_DELAY + 1);
  localparam int DEPTH = MAX_DELAY - 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t          state_r, state_s;
  logic [CW-1:0]   fill_cnt_r, fill_cnt_s;
  logic [CW-1:0]   cur_delay_r, cur_delay_s;
  logic [AW-1:0]   ptr_r, ptr_s;
  logic [DW-1:0]   byp_r;
  logic [DW-1:0]   ram_rdata_s;
  logic [DW-1:0]   data_s;
  logic            clr_r;
  logic            ram_en_s;
  logic            bypass_s;

  assign bypass_s = (cur_delay_r == CW'(1));

  // Next-state logic: a load always wins over a simultaneous advance.
  always_comb begin
    state_s     = state_r;
    fill_cnt_s  = fill_cnt_r;
    ptr_s       = ptr_r;
    cur_delay_s = cur_delay_r;
    ram_en_s    = 1'b0;
    if (cfg_load) begin
      cur_delay_s = CW'(clamp_delay(32'(cfg_delay), 32'(MAX_DELAY)));
      state_s     = S_FILL;
      fill_cnt_s  = CW'(0);
      ptr_s       = AW'(0);
    end else if (en) begin
      ram_en_s = !bypass_s;
      if (bypass_s) begin
        ptr_s = AW'(0);
      end else if (CW'(ptr_r) == (cur_delay_r - CW'(2))) begin
        ptr_s = AW'(0);
      end else begin
        ptr_s = ptr_r + AW'(1);
      end
      case (state_r)
        S_FILL: begin
          fill_cnt_s = fill_cnt_r + CW'(1);
          if (fill_cnt_s == cur_delay_r) begin
            state_s = S_RUN;
          end else begin
            state_s = S_FILL;
          end
        end
        S_RUN: begin
          state_s = S_RUN;
        end
        default: begin
          state_s    = S_FILL;
          fill_cnt_s = CW'(0);
        end
      endcase
    end else begin
      ram_en_s = 1'b0;
    end
  end

  // Control registers; buffer contents deliberately survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_FILL;
      fill_cnt_r  <= CW'(0);
      ptr_r       <= AW'(0);
      cur_delay_r <= CW'(MAX_DELAY);
      byp_r       <= DW'(0);
      clr_r       <= 1'b1;
    end else begin
      state_r     <= state_s;
      fill_cnt_r  <= fill_cnt_s;
      ptr_r       <= ptr_s;
      cur_delay_r <= cur_delay_s;
      if (en && !cfg_load) begin
        clr_r <= 1'b0;
        if (bypass_s) begin
          byp_r <= in;
        end
      end
    end
  end

  var_delay_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_en_s),
    .addr  (ptr_r),
    .wdata (in),
    .rdata (ram_rdata_s)
  );

  // Output select: every source is a flop, so out changes only on clock or reset.
  always_comb begin
    data_s = bypass_s ? byp_r : ram_rdata_s;
`ifdef VAR_DELAY_LINE_ZERO_FILL_EN
    if (state_r == S_RUN) begin
      out = data_s;
    end else begin
      out = DW'(0);
    end
`else
    if (clr_r) begin
      out = DW'(0);
    end else begin
      out = data_s;
    end
`endif
  end

  assign out_valid = (state_r == S_RUN);
  assign cur_delay = cur_delay_r;

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line: reference queue model plus scoreboard.
module tb_var_delay_line;

  localparam int W  = 32;
  localparam int L  = 4;
  localparam int M  = 64;
  localparam int DW = W * L;
  localparam int CW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          cfg_load = 1'b0;
  logic [CW-1:0] cfg_delay = '0;
  logic [DW-1:0] in_bus = '0;
  logic [DW-1:0] out;
  logic          out_valid;
  logic [CW-1:0] cur_delay;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic [CW-1:0] cur;
  } exp_t;

  typedef struct {
    logic          en;
    logic          load;
    logic [CW-1:0] cfg;
    logic          exp_valid;
  } vec_t;

  exp_t          sb[$];
  logic [DW-1:0] acc[$];
  int            md = M;

  var_delay_line #(.WIDTH(W), .LANES(L), .MAX_DELAY(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_load  (cfg_load),
    .cfg_delay (cfg_delay),
    .in        (in_bus),
    .out       (out),
    .out_valid (out_valid),
    .cur_delay (cur_delay)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lanes_of(input int t);
    logic [DW-1:0] v;
    for (int k = 0; k < L; k++) v[k*W +: W] = 32'(16 * t + k);
    return v;
  endfunction

  function automatic int ref_clamp(input int c);
    if (c == 0) return 1;
    if (c > M) return M;
    return c;
  endfunction

  task automatic model_reset();
    md = M;
    acc.delete();
  endtask

  // Drive one cycle, predict via the queue model, then compare after the edge.
  task automatic step(input logic e, input logic ld, input logic [CW-1:0] c, input logic [DW-1:0] d);
    exp_t x;
    en = e; cfg_load = ld; cfg_delay = c; in_bus = d;
    if (ld) begin
      md = ref_clamp(int'(c));
      acc.delete();
    end else if (e) begin
      acc.push_back(d);
      while (acc.size() > md) void'(acc.pop_front());
    end
    x.valid = (acc.size() == md);
    x.data  = x.valid ? acc[0] : '0;
    x.cur   = CW'(md);
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("out_valid", DW'(out_valid), DW'(x.valid));
    check("cur_delay", DW'(cur_delay), DW'(x.cur));
    if (x.valid) begin
      check("out_data", out, x.data);
    end else begin
`ifdef VAR_DELAY_LINE_ZERO_FILL_EN
      check("out_zero_fill", out, '0);
`endif
    end
  endtask

  vec_t stall_tbl[8];

  initial begin
    // Stall sequence at D=3: A,B,C,D accepted on the en=1 cycles.
    stall_tbl[0] = '{1'b0, 1'b1, 7'd3, 1'b0};
    stall_tbl[1] = '{1'b1, 1'b0, 7'd0, 1'b0};
    stall_tbl[2] = '{1'b0, 1'b0, 7'd0, 1'b0};
    stall_tbl[3] = '{1'b0, 1'b0, 7'd0, 1'b0};
    stall_tbl[4] = '{1'b1, 1'b0, 7'd0, 1'b0};
    stall_tbl[5] = '{1'b1, 1'b0, 7'd0, 1'b1};
    stall_tbl[6] = '{1'b0, 1'b0, 7'd0, 1'b1};
    stall_tbl[7] = '{1'b1, 1'b0, 7'd0, 1'b1};

    #22;
    check("reset_out", out, '0);
    check("reset_valid", DW'(out_valid), DW'(1'b0));
    check("reset_cur", DW'(cur_delay), DW'(M));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Basic delay D=5; the load edge carries en=1 and its sample is dropped.
    step(1'b1, 1'b1, 7'd5, lanes_of(99));
    for (int t = 0; t < 14; t++) begin
      step(1'b1, 1'b0, 7'd0, lanes_of(t));
      if (t >= 4) check("basic_lane", out, lanes_of(t - 4));
    end

    // Stall table with explicit validity expectations.
    for (int i = 0; i < 8; i++) begin
      step(stall_tbl[i].en, stall_tbl[i].load, stall_tbl[i].cfg, {L{32'hA0 + 32'(i)}});
      check("stall_tbl_valid", DW'(out_valid), DW'(stall_tbl[i].exp_valid));
    end
    check("stall_first_is_A", out, {L{32'hA4}});

    // cfg_delay must be ignored without cfg_load.
    step(1'b1, 1'b0, 7'd9, {L{32'h0000_0BEE}});

    // Clamp low and D=1 bypass.
    step(1'b1, 1'b1, 7'd0, {L{32'hDEAD_0000}});
    check("clamp_zero_cur", DW'(cur_delay), DW'(1));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 7'd0, {L{$urandom}});
      check("bypass_prev_in", out, in_bus);
    end
    step(1'b0, 1'b0, 7'd0, {L{32'h5555_5555}});

    // Clamp high (200 does not fit the port; 100 exercises the same saturation).
    step(1'b0, 1'b1, 7'd100, '0);
    check("clamp_high_cur", DW'(cur_delay), DW'(M));
    for (int i = 0; i < M + 6; i++) step(1'b1, 1'b0, 7'd0, {$urandom, $urandom, $urandom, $urandom});

    // Smallest buffered delay.
    step(1'b1, 1'b1, 7'd2, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 7'd0, {L{$urandom}});

    // Load colliding with en while running at D=4.
    step(1'b0, 1'b1, 7'd4, '0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 7'd0, lanes_of(200 + i));
    step(1'b1, 1'b1, 7'd2, {L{32'hBAD0_BAD0}});
    check("collide_drop", DW'(out_valid), DW'(1'b0));
    step(1'b1, 1'b0, 7'd0, lanes_of(300));
    check("collide_still_fill", DW'(out_valid), DW'(1'b0));
    step(1'b1, 1'b0, 7'd0, lanes_of(301));
    check("collide_rerise", out, lanes_of(300));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 7'd0, lanes_of(302 + i));

    // Reset mid-stream at D=6 with three samples in flight.
    step(1'b0, 1'b1, 7'd6, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 7'd0, {L{32'hFEED_0000 + 32'(i)}});
    #2 rst = 1'b1;
    #1;
    check("midrst_out", out, '0);
    check("midrst_valid", DW'(out_valid), DW'(1'b0));
    check("midrst_cur", DW'(cur_delay), DW'(M));
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 7'd0, lanes_of(400 + i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
